modexp_stream_ctrl: RTL
=======================

MODEXP_STREAM_CTRL -- requirements
Module: modexp_stream_ctrl

Interface
REQ-001 Parameter NLEN, default 1024: modulus width; N and exp are NLEN+1 bits.
REQ-002 Parameter TAG, default 2: extra headroom bits; base and result are NLEN+TAG+1 bits.
REQ-003 Parameter WORD, default 32: stream word width.
REQ-004 Derived NW = ceil((NLEN+TAG+1)/WORD): words per operand.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 s_data  in  WORD  operand input word.
REQ-008 s_valid  in  1  s_data valid.
REQ-009 s_ready  out  1  controller accepts s_data.
REQ-010 m_data  out  WORD  result output word.
REQ-011 m_valid  out  1  m_data valid.
REQ-012 m_ready  in  1  sink accepts m_data.
REQ-013 m_last  out  1  marks the final result word.
REQ-014 abort  in  1  synchronous; abandons the current job.
REQ-015 me_N  out  NLEN+1  modulus to the exponentiator.
REQ-016 me_exp  out  NLEN+1  exponent to the exponentiator.
REQ-017 me_base  out  NLEN+TAG+1  base to the exponentiator.
REQ-018 me_in_ready  out  1  start strobe to the exponentiator.
REQ-019 me_reset  out  1  synchronous active-high reset to the exponentiator.
REQ-020 me_out  in  NLEN+TAG+1  exponentiator result.
REQ-021 me_out_ready  in  1  exponentiator result valid (level; holds until me_reset).
REQ-022 busy  out  1  high in every state except LOAD.

Function
REQ-023 FSM states: LOAD, START, WAIT, CLEAR, SEND.
REQ-024 LOAD: s_ready=1; each s_valid&s_ready handshake stores one word and increments word counter wc (0..3*NW-1).
REQ-025 Word order: N words, then exp words, then base words; least-significant word first within each operand.
REQ-026 Width rule: words are zero-extended or truncated at the MSB to the target register width; bits above the width are discarded.
REQ-027 A handshake with wc=3*NW-1 clears wc and moves to START.
REQ-028 START: me_in_ready=1 for exactly one cycle, then move to WAIT.
REQ-029 WAIT: me_out_ready=1 captures me_out into result register R and moves to CLEAR; there is no timeout.
REQ-030 CLEAR: me_reset=1 for exactly one cycle, then move to SEND.
REQ-031 SEND: m_valid=1; m_data = R word oc (LSW first, zero-padded above NLEN+TAG); oc advances only on m_valid&m_ready.
REQ-032 m_last=1 while oc=NW-1; the handshake on that word clears oc and moves to LOAD.
REQ-033 m_data and m_last are held stable while m_valid=1 and m_ready=0.
REQ-034 me_N, me_exp and me_base are registered and change only in LOAD.
REQ-035 s_ready=0 outside LOAD; input words offered then are not consumed.
REQ-036 abort in any state other than CLEAR: clear wc and oc, then go to CLEAR; CLEAR exits to LOAD (not SEND) after an abort.
REQ-037 abort in CLEAR is ignored.
REQ-038 abort has priority over a same-cycle s or m handshake; that word is not consumed.
REQ-039 exp=0 is legal; the job completes normally with whatever result the exponentiator returns.

Reset
REQ-040 While reset=0: state=CLEAR, wc=oc=0, R=0, me_* operand registers=0, s_ready=0, m_valid=0, m_last=0, me_in_ready=0, me_reset=1, busy=1.
REQ-041 First edge after reset release: one CLEAR cycle, then LOAD; this guarantees the exponentiator starts from its idle state.
REQ-042 Reset asserted mid-job discards all loaded operands and any pending result.

Verification (NLEN=16, TAG=2, WORD=8, NW=3; exponentiator is the real one or a reference model)
REQ-043 Basic job: send 07,00,00 / 05,00,00 / 03,00,00 -> me_in_ready pulses once; then m_data 05,00,00 with m_last on the third word (3^5 mod 7 = 5).
REQ-044 Back-pressure: hold m_ready=0 for 10 cycles during SEND -> m_data/m_last stable and no word lost or duplicated.
REQ-045 Truncation: top N word = FF -> me_N bit 16 set and bits above 16 dropped.
REQ-046 Abort mid-LOAD at wc=4 -> one me_reset pulse, wc=0; a following full job returns the correct result.
REQ-047 Abort during WAIT -> me_reset pulses, no m_valid, return to LOAD.
REQ-048 Async reset during SEND -> m_valid drops immediately; me_reset=1; after release, LOAD is reached within 2 cycles.

Source files
------------

// File: rtl/modexp_stream_ctrl.sv
// modexp_stream_ctrl: streams N/exp/base words into a modular exponentiator and streams the result back out
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   s_data/s_valid/s_ready     operand word stream in (N, then exp, then base; LSW first)
//   m_data/m_valid/m_ready     result word stream out (LSW first), m_last on the final word
//   abort                      abandons the current job
//   me_N/me_exp/me_base        registered operands to the exponentiator
//   me_in_ready/me_reset       start strobe and synchronous reset to the exponentiator
//   me_out/me_out_ready        exponentiator result and its valid level
//   busy                       high whenever not waiting for operands
module modexp_stream_ctrl #(
    parameter int NLEN = 1024,
    parameter int TAG  = 2,
    parameter int WORD = 32,
    localparam int NW  = (NLEN + TAG + 1 + WORD - 1) / WORD,
    localparam int WIW = NW > 1 ? $clog2(NW) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [WORD-1:0]     m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    input  logic                abort,
    output logic [NLEN:0]       me_N,
    output logic [NLEN:0]       me_exp,
    output logic [NLEN+TAG:0]   me_base,
    output logic                me_in_ready,
    output logic                me_reset,
    input  logic [NLEN+TAG:0]   me_out,
    input  logic                me_out_ready,
    output logic                busy
);
    typedef enum logic [2:0] {LOAD, START, WAIT, CLEAR, SEND} state_t;
    state_t state, state_nx;
    logic [WIW-1:0] wi, oc;
    logic [1:0] op;
    logic aborted;
    logic [NLEN:0] n_nx, e_nx;
    logic [NLEN+TAG:0] b_nx, r;
    logic last_in, last_out;
    assign last_in     = wi == WIW'(NW - 1) && op == 2'd2;
    assign last_out    = oc == WIW'(NW - 1);
    assign s_ready     = state == LOAD;
    assign m_valid     = state == SEND;
    assign m_last      = m_valid && last_out;
    assign me_in_ready = state == START;
    assign me_reset    = state == CLEAR;
    assign busy        = state != LOAD;
    // Word wi lands in bits [wi*WORD +: WORD]; bits beyond each register's width simply have no home.
    always_comb begin
        n_nx = me_N;
        e_nx = me_exp;
        b_nx = me_base;
        for (int i = 0; i <= NLEN; i++)
            if (i / WORD == int'(wi)) begin
                n_nx[i] = s_data[i % WORD];
                e_nx[i] = s_data[i % WORD];
            end
        for (int i = 0; i <= NLEN + TAG; i++)
            if (i / WORD == int'(wi)) b_nx[i] = s_data[i % WORD];
    end
    always_comb begin
        m_data = '0;
        for (int i = 0; i <= NLEN + TAG; i++)
            if (i / WORD == int'(oc)) m_data[i % WORD] = r[i];
    end
    // CLEAR returns to LOAD after an abort or reset, and to SEND after a normal result capture.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = abort ? CLEAR : (s_valid && last_in) ? START : LOAD;
            START:   state_nx = abort ? CLEAR : WAIT;
            WAIT:    state_nx = (abort || me_out_ready) ? CLEAR : WAIT;
            CLEAR:   state_nx = aborted ? LOAD : SEND;
            SEND:    state_nx = abort ? CLEAR : (m_ready && last_out) ? LOAD : SEND;
            default: state_nx = CLEAR;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            aborted <= 1'b1;
            wi      <= '0;
            op      <= '0;
            oc      <= '0;
            r       <= '0;
            me_N    <= '0;
            me_exp  <= '0;
            me_base <= '0;
        end else begin
            state <= state_nx;
            if (abort && state != CLEAR) begin
                wi      <= '0;
                op      <= '0;
                oc      <= '0;
                aborted <= 1'b1;
            end else begin
                if (state == CLEAR) aborted <= 1'b0;
                if (s_ready && s_valid) begin
                    me_N    <= op == 2'd0 ? n_nx : me_N;
                    me_exp  <= op == 2'd1 ? e_nx : me_exp;
                    me_base <= op == 2'd2 ? b_nx : me_base;
                    wi      <= wi == WIW'(NW - 1) ? '0 : wi + 1'b1;
                    op      <= wi == WIW'(NW - 1) ? (op == 2'd2 ? 2'd0 : op + 2'd1) : op;
                end
                if (state == WAIT && me_out_ready) r <= me_out;
                if (m_valid && m_ready) oc <= last_out ? '0 : oc + 1'b1;
            end
        end
    end
endmodule
